// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch-side PC generator:
// FSM state, redirect-cause encoding and the IALIGN-to-mask function.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_SEQ,
    CAUSE_BRJ,
    CAUSE_JALR,
    CAUSE_TRAP,
    CAUSE_MRET
  } cause_e;

  // Low target bits that must be zero for the given instruction alignment.
  function automatic logic [1:0] ialign_mask(input int unsigned ialign);
    return (ialign == 32) ? 2'b11 : 2'b01;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-port bundle between the PC generator (master) and instruction fetch (slave).
// Signal names match the original flat ports for drop-in compatibility.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] o_pc;
  logic            o_pc_valid;
  logic            i_pc_ready;
  logic            o_flush;
  logic            o_misalign;
  logic [XLEN-1:0] o_misalign_addr;

  modport master (
    output o_pc,
    output o_pc_valid,
    input  i_pc_ready,
    output o_flush,
    output o_misalign,
    output o_misalign_addr
  );

  modport slave (
    input  o_pc,
    input  o_pc_valid,
    output i_pc_ready,
    input  o_flush,
    input  o_misalign,
    input  o_misalign_addr
  );
endinterface

// File: rtl/pc_target_sel.sv
// Combinational candidate-target generation, per-cycle priority select and
// misalignment detection for execute-stage redirects.
module pc_target_sel
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IALIGN = 32
) (
  input  state_e          state_i,
  input  logic            pc_valid_i,
  input  logic            pc_ready_i,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            brch_i,
  input  logic            zero_i,
  input  logic            jal_i,
  input  logic            jalr_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mepc_i,
  output cause_e          cause_o,
  output logic [XLEN-1:0] target_o,
  output logic            misalign_o
);

  localparam logic [1:0] MASK = ialign_mask(IALIGN);

  logic [XLEN-1:0] brj_tgt;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] trap_tgt;
  logic [XLEN-1:0] mret_tgt;
  logic            active;
  logic            run;
  logic            brj_take;
  logic            jalr_take;

  always_comb begin
    brj_tgt   = ex_pc_i + imm_i;
    jalr_tgt  = (rs1_i + imm_i) & ~XLEN'(1);
    trap_tgt  = mtvec_i & ~XLEN'(3);
    mret_tgt  = mepc_i & ~XLEN'(MASK);
    active    = (state_i == S_RUN) || (state_i == S_HALT);
    run       = (state_i == S_RUN);
    brj_take  = ex_valid_i & ((brch_i & ~zero_i) | jal_i);
    jalr_take = ex_valid_i & jalr_i;

    cause_o  = CAUSE_NONE;
    target_o = '0;
    if (active && trap_i) begin
      cause_o  = CAUSE_TRAP;
      target_o = trap_tgt;
    end else if (active && mret_i) begin
      cause_o  = CAUSE_MRET;
      target_o = mret_tgt;
    end else if (run && brj_take) begin
      cause_o  = CAUSE_BRJ;
      target_o = brj_tgt;
    end else if (run && jalr_take) begin
      cause_o  = CAUSE_JALR;
      target_o = jalr_tgt;
    end else if (run && pc_valid_i && pc_ready_i) begin
      cause_o  = CAUSE_SEQ;
    end

    // Trap/mret targets are masked by construction; only execute targets can fault.
    misalign_o = ((cause_o == CAUSE_BRJ) || (cause_o == CAUSE_JALR)) &&
                 target_o[1] && MASK[1];
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch front end: registered PC with a
// valid/ready fetch handshake, execute redirects, trap/mret vectoring and halt.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned     IALIGN     = 32,
  parameter int unsigned     INST_BYTES = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ex_valid,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic            i_brch,
  input  logic            i_jal,
  input  logic            i_jalr,
  input  logic            i_zero,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_trap,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_mepc,
  pc_gen_if.master        fetch
);

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            pc_valid_q;
  logic            flush_q;
  logic            misalign_q;
  logic [XLEN-1:0] misalign_addr_q;

  cause_e          cause_d;
  logic [XLEN-1:0] target_d;
  logic            misalign_d;

  pc_target_sel #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_sel (
    .state_i    (state_q),
    .pc_valid_i (pc_valid_q),
    .pc_ready_i (fetch.i_pc_ready),
    .ex_valid_i (i_ex_valid),
    .ex_pc_i    (i_ex_pc),
    .brch_i     (i_brch),
    .zero_i     (i_zero),
    .jal_i      (i_jal),
    .jalr_i     (i_jalr),
    .rs1_i      (i_rs1),
    .imm_i      (i_imm),
    .trap_i     (i_trap),
    .mtvec_i    (i_mtvec),
    .mret_i     (i_mret),
    .mepc_i     (i_mepc),
    .cause_o    (cause_d),
    .target_o   (target_d),
    .misalign_o (misalign_d)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= S_BOOT;
      pc_q            <= RESET_PC;
      pc_valid_q      <= 1'b0;
      flush_q         <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      if (state_q == S_BOOT) begin
        state_q    <= S_RUN;
        pc_valid_q <= 1'b1;
      end else begin
        unique case (cause_d)
          CAUSE_TRAP, CAUSE_MRET: begin
            state_q    <= S_RUN;
            pc_q       <= target_d;
            pc_valid_q <= 1'b1;
            flush_q    <= 1'b1;
          end
          CAUSE_BRJ, CAUSE_JALR: begin
            if (misalign_d) begin
              state_q         <= S_HALT;
              pc_valid_q      <= 1'b0;
              misalign_q      <= 1'b1;
              misalign_addr_q <= target_d;
            end else begin
              pc_q       <= target_d;
              pc_valid_q <= 1'b1;
              flush_q    <= 1'b1;
            end
          end
          CAUSE_SEQ: pc_q <= pc_q + XLEN'(INST_BYTES);
          default: ;
        endcase
      end
    end
  end

  assign fetch.o_pc            = pc_q;
  assign fetch.o_pc_valid      = pc_valid_q;
  assign fetch.o_flush         = flush_q;
  assign fetch.o_misalign      = misalign_q;
  assign fetch.o_misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: boot, stall, redirects, misalign/halt,
// trap/mret priority, wrap-around and mid-stall reset.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, brch, jal, jalr, zero, trap, mret;
  logic [31:0] ex_pc, rs1, imm, mtvec, mepc;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32)) fetch_if ();

  pc_gen #(
    .XLEN       (32),
    .RESET_PC   (32'h8000_0000),
    .IALIGN     (32),
    .INST_BYTES (4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ex_valid (ex_valid),
    .i_ex_pc    (ex_pc),
    .i_brch     (brch),
    .i_jal      (jal),
    .i_jalr     (jalr),
    .i_zero     (zero),
    .i_rs1      (rs1),
    .i_imm      (imm),
    .i_trap     (trap),
    .i_mtvec    (mtvec),
    .i_mret     (mret),
    .i_mepc     (mepc),
    .fetch      (fetch_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; brch = 0; jal = 0; jalr = 0; zero = 0;
    trap = 0; mret = 0;
    ex_pc = '0; rs1 = '0; imm = '0; mtvec = '0; mepc = '0;
  endtask

  task automatic check_pc(input string tag, input logic [31:0] pc, input logic valid);
    check({tag, ".pc"}, fetch_if.o_pc, pc);
    check({tag, ".valid"}, {31'b0, fetch_if.o_pc_valid}, {31'b0, valid});
  endtask

  initial begin
    clear_ex();
    rst = 1;
    fetch_if.i_pc_ready = 1;
    step(); step();
    check_pc("reset", 32'h8000_0000, 1'b0);
    check("reset.flush", {31'b0, fetch_if.o_flush}, 32'd0);
    check("reset.misalign", {31'b0, fetch_if.o_misalign}, 32'd0);
    check("reset.maddr", fetch_if.o_misalign_addr, 32'd0);

    rst = 0;
    step(); check_pc("boot", 32'h8000_0000, 1'b1);
    step(); check_pc("seq1", 32'h8000_0004, 1'b1);
    step(); check_pc("seq2", 32'h8000_0008, 1'b1);
    step(); step(); check_pc("seq4", 32'h8000_0010, 1'b1);

    fetch_if.i_pc_ready = 0;
    for (int i = 0; i < 4; i++) begin
      step(); check_pc("stall", 32'h8000_0010, 1'b1);
    end
    fetch_if.i_pc_ready = 1;
    step(); check_pc("unstall", 32'h8000_0014, 1'b1);

    // Taken branch, then the same branch not taken.
    ex_valid = 1; brch = 1; zero = 0; ex_pc = 32'h8000_0100; imm = 32'hFFFF_FFF0;
    step(); check_pc("br_taken", 32'h8000_00F0, 1'b1);
    check("br_taken.flush", {31'b0, fetch_if.o_flush}, 32'd1);
    clear_ex();
    step(); check_pc("after_br", 32'h8000_00F4, 1'b1);
    check("after_br.flush", {31'b0, fetch_if.o_flush}, 32'd0);
    ex_valid = 1; brch = 1; zero = 1; ex_pc = 32'h8000_0100; imm = 32'hFFFF_FFF0;
    step(); check_pc("br_not_taken", 32'h8000_00F8, 1'b1);
    check("br_not_taken.flush", {31'b0, fetch_if.o_flush}, 32'd0);
    clear_ex();

    // Misaligned JALR -> halt; execute redirects ignored while halted.
    ex_valid = 1; jalr = 1; rs1 = 32'h8000_0203; imm = 32'h0;
    step();
    check("jalr.misalign", {31'b0, fetch_if.o_misalign}, 32'd1);
    check("jalr.maddr", fetch_if.o_misalign_addr, 32'h8000_0202);
    check_pc("jalr.halt", 32'h8000_00F8, 1'b0);
    clear_ex();
    ex_valid = 1; jal = 1; ex_pc = 32'h8000_0000; imm = 32'h40;
    step();
    check_pc("halt.ignore", 32'h8000_00F8, 1'b0);
    check("halt.misalign_pulse", {31'b0, fetch_if.o_misalign}, 32'd0);
    check("halt.maddr_held", fetch_if.o_misalign_addr, 32'h8000_0202);
    clear_ex();
    trap = 1; mtvec = 32'h8000_1001;
    step(); check_pc("halt.trap", 32'h8000_1000, 1'b1);
    clear_ex();

    // trap > mret > jal in the same cycle, then mret alone (bit 1 masked).
    trap = 1; mtvec = 32'h8000_2003; mret = 1; mepc = 32'h8000_0500;
    ex_valid = 1; jal = 1; ex_pc = 32'h8000_0000; imm = 32'h8;
    step(); check_pc("prio.trap", 32'h8000_2000, 1'b1);
    clear_ex();
    mret = 1; mepc = 32'h8000_0044;
    step(); check_pc("mret", 32'h8000_0044, 1'b1);
    mepc = 32'h8000_0047;
    step(); check_pc("mret.mask", 32'h8000_0044, 1'b1);
    clear_ex();

    // Trap beats a misaligned JALR: no misalign pulse.
    trap = 1; mtvec = 32'h8000_3000; ex_valid = 1; jalr = 1; rs1 = 32'h8000_0002;
    step(); check_pc("trap_vs_mis", 32'h8000_3000, 1'b1);
    check("trap_vs_mis.misalign", {31'b0, fetch_if.o_misalign}, 32'd0);
    clear_ex();

    // Branch/jal beats jalr when both asserted.
    ex_valid = 1; brch = 1; zero = 0; jalr = 1; ex_pc = 32'h8000_0000; imm = 32'h20;
    rs1 = 32'h9000_0000;
    step(); check_pc("brj_vs_jalr", 32'h8000_0020, 1'b1);
    clear_ex();

    // Aligned JALR redirect while stalled supersedes the pending request.
    fetch_if.i_pc_ready = 0;
    ex_valid = 1; jalr = 1; rs1 = 32'h8000_0401; imm = 32'h3;
    step(); check_pc("jalr.stalled", 32'h8000_0404, 1'b1);
    clear_ex();
    fetch_if.i_pc_ready = 1;

    // Wrap-around.
    ex_valid = 1; jal = 1; ex_pc = 32'hFFFF_FFF0; imm = 32'hC;
    step(); check_pc("to_top", 32'hFFFF_FFFC, 1'b1);
    clear_ex();
    step(); check_pc("wrap", 32'h0000_0000, 1'b1);
    step(); check_pc("post_wrap", 32'h0000_0004, 1'b1);

    // Reset during a stall.
    fetch_if.i_pc_ready = 0;
    step(); check_pc("stall2", 32'h0000_0004, 1'b1);
    rst = 1; trap = 1; mtvec = 32'h1234_5678;
    step(); check_pc("mid_reset", 32'h8000_0000, 1'b0);
    clear_ex();
    rst = 0;
    step(); check_pc("reboot", 32'h8000_0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
